// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// frame header default and the running-checksum helper.
package cpu_pkg;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      LEN_H = 4'd1,
      LEN_L = 4'd2,
      ADR_H = 4'd3,
      ADR_L = 4'd4,
      DAT_H = 4'd5,
      DAT_L = 4'd6,
      WRITE = 4'd7,
      CHECK = 4'd8
   } loader_state_e;

   localparam logic [7:0]  HEADER_DEFAULT  = 8'hA5;
   localparam logic [15:0] TIMEOUT_DEFAULT = 16'hFFFF;

   function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
      return chk ^ b;
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter: expired fires on the TIMEOUT-th consecutive
// enabled cycle without a kick.
module loader_timeout #(
   parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
   input  logic clock,
   input  logic reset_n,
   input  logic kick,
   input  logic enable,
   output logic expired
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Idle-cycle count: cleared by traffic or when disabled, saturates at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (kick || !enable) begin
         cnt_d = 16'd0;
      end else if (cnt_q != TIMEOUT - 16'd1) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && !kick && (cnt_q == TIMEOUT - 16'd1);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses framed instruction words, writes them into
// instruction memory and holds the CPU until a frame checks out.
module imem_loader
   import cpu_pkg::*;
#(
   parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT,
   parameter logic [7:0]  HEADER  = HEADER_DEFAULT
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [15:0] imem_addr,
   output logic [15:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   loader_state_e state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  hi_q, hi_d;
   logic [7:0]  chk_q, chk_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        hold_q, hold_d;
   logic        we_q, we_d;
   logic [15:0] waddr_q, waddr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        rx_ready_q, rx_ready_d;
   logic        accept_s;
   logic        enable_s;
   logic        expired_s;

   assign accept_s = rx_valid && rx_ready_q;
   assign enable_s = (state_q != IDLE) && (state_q != WRITE);

   loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clock   (clock),
      .reset_n (reset_n),
      .kick    (accept_s),
      .enable  (enable_s),
      .expired (expired_s)
   );

   // Frame parser: next state, checksum, address/count and write strobe.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      addr_d  = addr_q;
      hi_d    = hi_q;
      chk_d   = chk_q;
      done_d  = done_q;
      error_d = error_q;
      hold_d  = hold_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (expired_s) begin
         state_d = IDLE;
         error_d = 1'b1;
         hold_d  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s && (rx_data == HEADER)) begin
                  hold_d  = 1'b1;
                  done_d  = 1'b0;
                  error_d = 1'b0;
                  chk_d   = 8'h00;
                  state_d = LEN_H;
               end else begin
                  state_d = IDLE;
               end
            end
            LEN_H, LEN_L, ADR_H, ADR_L, DAT_H, DAT_L: begin
               if (accept_s) begin
                  chk_d = chk_update(chk_q, rx_data);
                  case (state_q)
                     LEN_H:   begin len_d[15:8] = rx_data; state_d = LEN_L; end
                     LEN_L:   begin len_d[7:0]  = rx_data; state_d = ADR_H; end
                     ADR_H:   begin addr_d[15:8] = rx_data; state_d = ADR_L; end
                     ADR_L: begin
                        // The base address is forced word aligned.
                        addr_d  = {addr_q[15:8], rx_data[7:1], 1'b0};
                        state_d = (len_q == 16'd0) ? CHECK : DAT_H;
                     end
                     DAT_H:   begin hi_d = rx_data; state_d = DAT_L; end
                     DAT_L: begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = {hi_q, rx_data};
                        state_d = WRITE;
                     end
                     default: state_d = IDLE;
                  endcase
               end else begin
                  state_d = state_q;
               end
            end
            WRITE: begin
               addr_d  = addr_q + 16'd2;
               len_d   = len_q - 16'd1;
               state_d = (len_q == 16'd1) ? CHECK : DAT_H;
            end
            CHECK: begin
               if (accept_s) begin
                  if (rx_data == chk_q) begin
                     done_d = 1'b1;
                     hold_d = 1'b0;
                  end else begin
                     error_d = 1'b1;
                     hold_d  = 1'b1;
                  end
                  state_d = IDLE;
               end else begin
                  state_d = CHECK;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      rx_ready_d = (state_d != WRITE);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         len_q      <= 16'd0;
         addr_q     <= 16'd0;
         hi_q       <= 8'h00;
         chk_q      <= 8'h00;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         hold_q     <= 1'b1;
         we_q       <= 1'b0;
         waddr_q    <= 16'd0;
         wdata_q    <= 16'd0;
         rx_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         addr_q     <= addr_d;
         hi_q       <= hi_d;
         chk_q      <= chk_d;
         done_q     <= done_d;
         error_q    <= error_d;
         hold_q     <= hold_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         rx_ready_q <= rx_ready_d;
      end
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = waddr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loads, checksum failure, empty frame,
// address wrap, inter-byte timeout and mid-frame reset.
module tb_imem_loader;
   import cpu_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready;
   logic        imem_we;
   logic [15:0] imem_addr;
   logic [15:0] imem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int n_cmp = 0;
   int n_fail = 0;
   logic [15:0] wa_q[$];
   logic [15:0] wd_q[$];
   logic [7:0]  fb[$];

   imem_loader #(.TIMEOUT(16'd16), .HEADER(8'hA5)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;

   // Record every write strobe seen between clock edges.
   always @(negedge clock) begin
      if (imem_we === 1'b1) begin
         wa_q.push_back(imem_addr);
         wd_q.push_back(imem_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clock);
      while (rx_ready !== 1'b1 && n < 8) begin
         @(negedge clock);
         n++;
      end
      check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clock);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] chk);
      send_byte(8'hA5);
      foreach (fb[i]) send_byte(fb[i]);
      send_byte(chk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #12;
      check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_we", {31'd0, imem_we}, 32'd0);
      check("rst_addr", {16'd0, imem_addr}, 32'd0);
      check("rst_wdata", {16'd0, imem_wdata}, 32'd0);
      check("rst_ready", {31'd0, rx_ready}, 32'd1);
      @(negedge clock);
      reset_n = 1'b1;

      send_byte(8'h33);
      check("noise_idle_hold", {31'd0, cpu_hold}, 32'd1);
      check("noise_idle_done", {31'd0, done}, 32'd0);

      // Two-word load, checksum 00^02^01^00^12^34^56^78 = 0B.
      fb = '{8'h00, 8'h02, 8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
      wa_q.delete(); wd_q.delete();
      send_frame(8'h0B);
      check("f1_nwr", wa_q.size(), 32'd2);
      check("f1_a0", {16'd0, wa_q[0]}, 32'h0100);
      check("f1_d0", {16'd0, wd_q[0]}, 32'h1234);
      check("f1_a1", {16'd0, wa_q[1]}, 32'h0102);
      check("f1_d1", {16'd0, wd_q[1]}, 32'h5678);
      check("f1_done", {31'd0, done}, 32'd1);
      check("f1_error", {31'd0, error}, 32'd0);
      check("f1_hold", {31'd0, cpu_hold}, 32'd0);
      check("f1_addr_held", {16'd0, imem_addr}, 32'h0102);
      check("f1_wdata_held", {16'd0, imem_wdata}, 32'h5678);

      send_byte(8'h5A);
      check("noise_done_done", {31'd0, done}, 32'd1);
      check("noise_done_hold", {31'd0, cpu_hold}, 32'd0);

      wa_q.delete(); wd_q.delete();
      send_frame(8'h00);
      check("badchk_nwr", wa_q.size(), 32'd2);
      check("badchk_d1", {16'd0, wd_q[1]}, 32'h5678);
      check("badchk_error", {31'd0, error}, 32'd1);
      check("badchk_done", {31'd0, done}, 32'd0);
      check("badchk_hold", {31'd0, cpu_hold}, 32'd1);

      fb = '{8'h00, 8'h00, 8'hFF, 8'hFE};
      wa_q.delete(); wd_q.delete();
      send_frame(8'h01);
      check("empty_nwr", wa_q.size(), 32'd0);
      check("empty_done", {31'd0, done}, 32'd1);
      check("empty_error", {31'd0, error}, 32'd0);

      // Address wrap, checksum 00^02^FF^FE^AA^BB^CC^DD = 03.
      fb = '{8'h00, 8'h02, 8'hFF, 8'hFE, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      wa_q.delete(); wd_q.delete();
      send_frame(8'h03);
      check("wrap_nwr", wa_q.size(), 32'd2);
      check("wrap_a0", {16'd0, wa_q[0]}, 32'hFFFE);
      check("wrap_d0", {16'd0, wd_q[0]}, 32'hAABB);
      check("wrap_a1", {16'd0, wa_q[1]}, 32'h0000);
      check("wrap_d1", {16'd0, wd_q[1]}, 32'hCCDD);
      check("wrap_done", {31'd0, done}, 32'd1);

      send_byte(8'hA5);
      send_byte(8'h00);
      repeat (15) @(negedge clock);
      check("to_15_error", {31'd0, error}, 32'd0);
      @(negedge clock);
      check("to_16_error", {31'd0, error}, 32'd1);
      check("to_16_hold", {31'd0, cpu_hold}, 32'd1);
      check("to_16_state", {28'd0, dut.state_q}, {28'd0, IDLE});

      fb = '{8'h00, 8'h02, 8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
      send_frame(8'h0B);
      check("to_recover_done", {31'd0, done}, 32'd1);
      check("to_recover_error", {31'd0, error}, 32'd0);

      wa_q.delete(); wd_q.delete();
      send_byte(8'hA5);
      for (int i = 0; i < 7; i++) send_byte(fb[i]);
      reset_n = 1'b0;
      #1;
      check("mrst_state", {28'd0, dut.state_q}, {28'd0, IDLE});
      check("mrst_addr", {16'd0, imem_addr}, 32'd0);
      check("mrst_wdata", {16'd0, imem_wdata}, 32'd0);
      check("mrst_hold", {31'd0, cpu_hold}, 32'd1);
      check("mrst_we", {31'd0, imem_we}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      send_byte(8'h78);
      send_byte(8'h0B);
      repeat (3) @(negedge clock);
      check("mrst_nwr", wa_q.size(), 32'd1);
      check("mrst_after_hold", {31'd0, cpu_hold}, 32'd1);
      check("mrst_after_done", {31'd0, done}, 32'd0);
      check("mrst_after_error", {31'd0, error}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
